// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit signal bundle: stage register numbers and control
// bits in, stall/flush/forward selects and MDU status out.
interface hazard_ctrl_if #(
   parameter int unsigned CNT_W = 32
);
   logic [4:0]       RsD, RtD, RsE, RtE;
   logic [4:0]       WriteRegE, WriteRegM, WriteRegW;
   logic             BranchD, PCSrcD, MdStartD, MfHiLoD;
   logic             RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, RegWriteW;
   logic             StallF, StallD, FlushD, FlushE;
   logic             ForwardAD, ForwardBD;
   logic [1:0]       ForwardAE, ForwardBE;
   logic             MduGoE, MduBusy;
   logic [CNT_W-1:0] StallCount;

   modport master (
      output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
             BranchD, PCSrcD, MdStartD, MfHiLoD,
             RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, RegWriteW,
      input  StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD,
             ForwardAE, ForwardBE, MduGoE, MduBusy, StallCount
   );

   modport slave (
      input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
             BranchD, PCSrcD, MdStartD, MfHiLoD,
             RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, RegWriteW,
      output StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD,
             ForwardAE, ForwardBE, MduGoE, MduBusy, StallCount
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline, with MDU
// occupancy sequencing and a saturating stall-cycle counter.
module hazard_ctrl #(
   parameter int unsigned MDU_LAT = 32,
   parameter int unsigned CNT_W   = 32
) (
   input logic          clk,
   input logic          Reset,
   hazard_ctrl_if.slave hz
);
   localparam logic [5:0] LAT = 6'(MDU_LAT);

   logic [5:0]       cnt_q, cnt_d;
   logic             go_q, go_d;
   logic [CNT_W-1:0] scount_q, scount_d;

   logic lwstall, branchstall, mdstall, stall, busy, accept;

   // A nonzero register number that a writing stage is producing.
   function automatic logic hit(input logic [4:0] src, input logic we,
                                input logic [4:0] dst);
      return (src != 5'd0) && we && (src == dst);
   endfunction

   always_comb begin
      busy = (cnt_q != 6'd0);

      lwstall = hz.MemtoRegE && (hz.RtE != 5'd0) &&
                ((hz.RtE == hz.RsD) || (hz.RtE == hz.RtD));

      branchstall = hz.BranchD &&
         (hit(hz.WriteRegE, hz.RegWriteE, hz.RsD) ||
          hit(hz.WriteRegE, hz.RegWriteE, hz.RtD) ||
          hit(hz.WriteRegM, hz.MemtoRegM, hz.RsD) ||
          hit(hz.WriteRegM, hz.MemtoRegM, hz.RtD));

      mdstall = (hz.MdStartD || hz.MfHiLoD) && busy;
      stall   = lwstall || branchstall || mdstall;
      accept  = hz.MdStartD && !stall;
   end

   always_comb begin
      hz.StallF    = stall;
      hz.StallD    = stall;
      hz.FlushE    = stall;
      hz.FlushD    = hz.PCSrcD && !stall;
      hz.ForwardAD = hit(hz.RsD, hz.RegWriteM, hz.WriteRegM);
      hz.ForwardBD = hit(hz.RtD, hz.RegWriteM, hz.WriteRegM);

      hz.ForwardAE = 2'b00;
      if (hit(hz.RsE, hz.RegWriteM, hz.WriteRegM))      hz.ForwardAE = 2'b10;
      else if (hit(hz.RsE, hz.RegWriteW, hz.WriteRegW)) hz.ForwardAE = 2'b01;

      hz.ForwardBE = 2'b00;
      if (hit(hz.RtE, hz.RegWriteM, hz.WriteRegM))      hz.ForwardBE = 2'b10;
      else if (hit(hz.RtE, hz.RegWriteW, hz.WriteRegW)) hz.ForwardBE = 2'b01;

      hz.MduGoE     = go_q;
      hz.MduBusy    = busy;
      hz.StallCount = scount_q;
   end

   // A start can only be accepted at cnt==0, so load and decrement never collide.
   always_comb begin
      cnt_d = cnt_q;
      if (accept)    cnt_d = LAT;
      else if (busy) cnt_d = cnt_q - 6'd1;

      go_d = accept;

      scount_d = scount_q;
      if (stall && (scount_q != '1)) scount_d = scount_q + 1'b1;
   end

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         cnt_q    <= '0;
         go_q     <= 1'b0;
         scount_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         go_q     <= go_d;
         scount_q <= scount_d;
      end
   end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench: the driver queues hand-computed expectations, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_ctrl;
   localparam int unsigned CNT_W = 4;

   logic clk;
   logic Reset;

   hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

   hazard_ctrl #(.MDU_LAT(4), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .Reset (Reset),
      .hz    (hz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst_n;
      logic [4:0] rsd, rtd, rse, rte, wre, wrm, wrw;
      logic       br, pcsrc, mds, mfh, rwe, m2re, rwm, m2rm, rww;
   } in_t;

   typedef struct {
      logic       stall, flushd, fad, fbd, go, busy;
      logic [1:0] fae, fbe;
      logic [3:0] sc;
      int         idx;
   } exp_t;

   exp_t exp_q[$];
   int   vectors;
   int   miscompares;
   int   vec_id;

   function automatic in_t in0();
      in_t v;
      v.rst_n = 1'b1;
      v.rsd = 0; v.rtd = 0; v.rse = 0; v.rte = 0;
      v.wre = 0; v.wrm = 0; v.wrw = 0;
      v.br = 0; v.pcsrc = 0; v.mds = 0; v.mfh = 0;
      v.rwe = 0; v.m2re = 0; v.rwm = 0; v.m2rm = 0; v.rww = 0;
      return v;
   endfunction

   function automatic exp_t ex0();
      exp_t e;
      e.stall = 0; e.flushd = 0; e.fad = 0; e.fbd = 0;
      e.go = 0; e.busy = 0; e.fae = 0; e.fbe = 0; e.sc = 0; e.idx = 0;
      return e;
   endfunction

   task automatic step(input in_t v, input exp_t e);
      @(posedge clk);
      #1;
      Reset        = v.rst_n;
      hz.RsD       = v.rsd;  hz.RtD = v.rtd;
      hz.RsE       = v.rse;  hz.RtE = v.rte;
      hz.WriteRegE = v.wre;  hz.WriteRegM = v.wrm; hz.WriteRegW = v.wrw;
      hz.BranchD   = v.br;   hz.PCSrcD = v.pcsrc;
      hz.MdStartD  = v.mds;  hz.MfHiLoD = v.mfh;
      hz.RegWriteE = v.rwe;  hz.MemtoRegE = v.m2re;
      hz.RegWriteM = v.rwm;  hz.MemtoRegM = v.m2rm;
      hz.RegWriteW = v.rww;
      e.idx = vec_id;
      vec_id++;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input int idx, input int act, input int req);
      if (act != req) begin
         miscompares++;
         $display("FAIL vec%0d %s: got %0d expected %0d", idx, name, act, req);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            chk("StallF",     e.idx, int'(hz.StallF),     int'(e.stall));
            chk("StallD",     e.idx, int'(hz.StallD),     int'(e.stall));
            chk("FlushE",     e.idx, int'(hz.FlushE),     int'(e.stall));
            chk("FlushD",     e.idx, int'(hz.FlushD),     int'(e.flushd));
            chk("ForwardAD",  e.idx, int'(hz.ForwardAD),  int'(e.fad));
            chk("ForwardBD",  e.idx, int'(hz.ForwardBD),  int'(e.fbd));
            chk("ForwardAE",  e.idx, int'(hz.ForwardAE),  int'(e.fae));
            chk("ForwardBE",  e.idx, int'(hz.ForwardBE),  int'(e.fbe));
            chk("MduGoE",     e.idx, int'(hz.MduGoE),     int'(e.go));
            chk("MduBusy",    e.idx, int'(hz.MduBusy),    int'(e.busy));
            chk("StallCount", e.idx, int'(hz.StallCount), int'(e.sc));
         end
      end
   end

   initial begin : driver
      in_t  v;
      exp_t e;
      vectors = 0; miscompares = 0; vec_id = 0;
      Reset = 1'b0;

      // v0: in reset, v1: released
      v = in0(); v.rst_n = 0; e = ex0(); step(v, e);
      v = in0(); e = ex0(); step(v, e);

      // ALU forwarding priority and $0 exclusion
      v = in0(); v.rwm = 1; v.wrm = 8; v.rse = 8; v.rww = 1; v.wrw = 8;
      e = ex0(); e.fae = 2'b10; step(v, e);
      v.rwm = 0; e = ex0(); e.fae = 2'b01; step(v, e);
      v = in0(); v.rwm = 1; v.wrm = 0; v.rse = 0; v.rww = 1; v.wrw = 8; v.rte = 8;
      e = ex0(); e.fbe = 2'b01; step(v, e);
      v = in0(); v.rwm = 1; v.wrm = 8; v.rte = 8; v.rsd = 8; v.rtd = 8;
      e = ex0(); e.fbe = 2'b10; e.fad = 1; e.fbd = 1; step(v, e);

      // load-use: one stall cycle, counted on the following edge
      v = in0(); v.m2re = 1; v.rte = 9; v.rsd = 9;
      e = ex0(); e.stall = 1; step(v, e);
      v = in0(); e = ex0(); e.sc = 1; step(v, e);

      // taken branch waiting on E-stage producer, then forwarded from M
      v = in0(); v.br = 1; v.rsd = 5; v.rwe = 1; v.wre = 5; v.pcsrc = 1;
      e = ex0(); e.stall = 1; e.sc = 1; step(v, e);
      v = in0(); v.br = 1; v.rsd = 5; v.pcsrc = 1; v.rwm = 1; v.wrm = 5;
      e = ex0(); e.fad = 1; e.flushd = 1; e.sc = 2; step(v, e);

      // $0 everywhere: no stall, no forward
      v = in0(); v.br = 1; v.rwe = 1; v.m2re = 1; v.m2rm = 1; v.rwm = 1;
      e = ex0(); e.sc = 2; step(v, e);
      // branch behind a load in M
      v = in0(); v.br = 1; v.rtd = 7; v.m2rm = 1; v.rwm = 1; v.wrm = 7;
      e = ex0(); e.stall = 1; e.fbd = 1; e.sc = 2; step(v, e);
      v = in0(); e = ex0(); e.sc = 3; step(v, e);

      // MDU: start at cycle 0, MfHiLo stalls cycles 2..4, free at 5
      v = in0(); v.mds = 1; e = ex0(); e.sc = 3; step(v, e);
      v = in0(); e = ex0(); e.go = 1; e.busy = 1; e.sc = 3; step(v, e);
      v = in0(); v.mfh = 1;
      e = ex0(); e.busy = 1; e.stall = 1; e.sc = 3; step(v, e);
      e.sc = 4; step(v, e);
      e.sc = 5; step(v, e);
      e = ex0(); e.sc = 6; step(v, e);

      // start while cnt==1 stalls, accepted one cycle later
      v = in0(); v.mds = 1; e = ex0(); e.sc = 6; step(v, e);
      v = in0(); e = ex0(); e.go = 1; e.busy = 1; e.sc = 6; step(v, e);
      e.go = 0; step(v, e);
      step(v, e);
      v.mds = 1; e.stall = 1; step(v, e);
      e = ex0(); e.sc = 7; step(v, e);
      v = in0(); e = ex0(); e.go = 1; e.busy = 1; e.sc = 7; step(v, e);

      // async reset mid-operation; combinational forwarding still live
      v = in0(); v.rst_n = 0; v.rse = 8; v.rwm = 1; v.wrm = 8;
      e = ex0(); e.fae = 2'b10; step(v, e);
      v = in0(); e = ex0(); step(v, e);

      // saturation: 20 stall cycles into a 4-bit counter
      for (int j = 0; j < 20; j++) begin
         v = in0(); v.m2re = 1; v.rte = 3; v.rtd = 3;
         e = ex0(); e.stall = 1; e.sc = 4'((j > 15) ? 15 : j);
         step(v, e);
      end
      v = in0(); e = ex0(); e.sc = 15; step(v, e);

      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
      if (exp_q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: %0d vectors unchecked, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
